leglite_fetch: RTL and testbench
================================

// Module: leglite_fetch
// PURPOSE
//  Instruction fetch unit for LEGLite. Produces the 16-bit instruction word whose
//  opcode field instr[15:13] feeds the Control decoder. Reads instruction memory
//  through a req/ack handshake, holds the instruction until decode accepts it,
//  then advances the PC sequentially or to a branch target supplied by decode.
// PARAMETERS
//  RESET_PC   16'h0000  PC loaded on reset (bit 0 forced to 0)
// PORTS
//  clock        in   1   system clock, rising edge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  16  byte address of fetched word (bit 0 always 0)
//  imem_ack     in   1   single-cycle: imem_rdata valid this cycle
//  imem_rdata   in   16  instruction word from memory
//  instr        out  16  held instruction to decode/Control (opcode = [15:13])
//  instr_pc     out  16  address of instr
//  instr_valid  out  1   instr holds a valid, not-yet-accepted instruction
//  instr_ready  in   1   decode accepts instr this cycle
//  br_taken     in   1   with accept: instr is a taken branch (branch & zero)
//  br_offset    in   8   signed word offset of the branch, two's complement
//  fetch_count  out  16  count of accepted instructions, wraps at 2^16
// BEHAVIOUR
//  Reset:
//   - state=IDLE, pc=RESET_PC&16'hFFFE.
//   - imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
//   - Reset overrides everything; a request in flight is abandoned, not completed.
//  States:
//   IDLE  : one cycle after reset; imem_req=0; always goes to FETCH.
//   FETCH : imem_req=1, imem_addr=pc, both held stable until imem_ack.
//           On imem_ack: instr<=imem_rdata, instr_pc<=pc, go to ISSUE.
//           Ack in the first FETCH cycle (zero wait) is legal.
//   ISSUE : imem_req=0, instr_valid=1; instr and instr_pc stable.
//           On instr_valid&instr_ready (accept): compute pc, increment
//           fetch_count, go to FETCH.
//  Next pc on accept:
//   - br_taken=0: pc <= instr_pc + 2.
//   - br_taken=1: pc <= instr_pc + 2 + (sext16(br_offset) << 1).
//   - All arithmetic is mod 2^16: 16'hFFFE + 2 = 16'h0000; negative targets wrap.
//   - br_taken and br_offset are sampled only on accept; ignored otherwise.
//  Timing and protocol:
//   - Min throughput: 1 instruction per 2 cycles. Accept-to-next-req latency: 1 cycle.
//   - imem_ack outside FETCH is ignored; imem_rdata is don't-care without ack.
//   - Only one fetch is outstanding at a time; no prefetch, no flush needed.
//   - instr_ready while instr_valid=0 has no effect.
//   - instr_valid drops the cycle after accept.
// TESTING
//  1 Reset 2 cycles, release -> IDLE 1 cycle, then imem_req=1 with imem_addr=0x0000;
//    instr_valid=0; fetch_count=0.
//  2 Zero-wait memory returns 0x0000,0x2000,0x6000 with instr_ready=1 ->
//    addresses 0,2,4; instr matches in order; opcodes 0,1,3; fetch_count=3.
//  3 Ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles;
//    instr_valid=0 until the cycle after ack.
//  4 instr_ready low 5 cycles in ISSUE -> instr/instr_pc stable, imem_req=0,
//    fetch_count unchanged; raise ready -> next req on the following cycle.
//  5 beq at instr_pc=0x0010: br_taken=1, br_offset=8'hFD -> next addr 0x000C.
//    br_taken=0 -> next addr 0x0012. offset 8'h7F from 0x0000 -> 0x0100.
//  6 Wrap and reset: accept at 0xFFFE -> next addr 0x0000.
//    Reset asserted mid-FETCH (ack pending) -> imem_req=0 next cycle, refetch at
//    RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/leglite_fetch.sv
// LEGLite instruction fetch unit: fetches one 16-bit word at a time over a req/ack
// handshake, holds it for decode, then advances the PC sequentially or to a branch target.
module leglite_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [7:0]  br_offset,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] br_disp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Branch displacement is a signed word offset, so it is scaled to bytes here.
  always_comb begin
    br_disp       = 16'h0000;
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;

    if (br_taken) begin
      br_disp = {{7{br_offset[7]}}, br_offset, 1'b0};
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_d          = instr_pc_q + 16'd2 + br_disp;
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_leglite_fetch.sv
// Directed bench for leglite_fetch: drives the memory and decode sides by hand
// and checks every observable output against hand-computed values.
module tb_leglite_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [7:0]  br_offset;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  leglite_fetch #(.RESET_PC(16'h0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .fetch_count (fetch_count)
  );

  always #5 clock = ~clock;

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Serve one fetch at exp_addr after wait_cycles of no ack, then check the held word.
  task automatic apply_fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                             input int wait_cycles);
    imem_ack = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      check_output("wait_req", {15'd0, imem_req}, 16'd1);
      check_output("wait_addr", imem_addr, exp_addr);
      check_output("wait_valid", {15'd0, instr_valid}, 16'd0);
      step();
    end
    check_output("ack_req", {15'd0, imem_req}, 16'd1);
    check_output("ack_addr", imem_addr, exp_addr);
    check_output("ack_valid", {15'd0, instr_valid}, 16'd0);
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    check_output("issue_valid", {15'd0, instr_valid}, 16'd1);
    check_output("issue_req", {15'd0, imem_req}, 16'd0);
    check_output("issue_instr", instr, data);
    check_output("issue_opcode", {13'd0, instr[15:13]}, {13'd0, data[15:13]});
    check_output("issue_pc", instr_pc, exp_addr);
  endtask

  // Accept the held instruction and check the following request.
  task automatic apply_accept(input logic taken, input logic [7:0] offset,
                              input logic [15:0] exp_next, input logic [15:0] exp_count);
    instr_ready = 1'b1;
    br_taken    = taken;
    br_offset   = offset;
    step();
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_offset   = 8'h00;
    check_output("acc_valid", {15'd0, instr_valid}, 16'd0);
    check_output("acc_req", {15'd0, imem_req}, 16'd1);
    check_output("acc_next_addr", imem_addr, exp_next);
    check_output("acc_count", fetch_count, exp_count);
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_offset   = 8'h00;

    // Reset for two cycles, then one IDLE cycle before the first request.
    step();
    step();
    reset = 1'b0;
    check_output("rst_req", {15'd0, imem_req}, 16'd0);
    check_output("rst_valid", {15'd0, instr_valid}, 16'd0);
    check_output("rst_instr", instr, 16'h0000);
    check_output("rst_instr_pc", instr_pc, 16'h0000);
    check_output("rst_count", fetch_count, 16'h0000);
    step();
    check_output("first_req", {15'd0, imem_req}, 16'd1);
    check_output("first_addr", imem_addr, 16'h0000);
    check_output("first_valid", {15'd0, instr_valid}, 16'd0);
    check_output("first_count", fetch_count, 16'h0000);

    // Zero-wait memory, ready held high even while fetching.
    instr_ready = 1'b1;
    apply_fetch(16'h0000, 16'h0000, 0);
    apply_accept(1'b0, 8'h00, 16'h0002, 16'd1);
    instr_ready = 1'b1;
    apply_fetch(16'h0002, 16'h2000, 0);
    apply_accept(1'b0, 8'h00, 16'h0004, 16'd2);
    instr_ready = 1'b1;
    apply_fetch(16'h0004, 16'h6000, 0);
    apply_accept(1'b0, 8'h00, 16'h0006, 16'd3);

    // Ack delayed three cycles.
    apply_fetch(16'h0006, 16'h4000, 3);

    // Decode stalls five cycles; stray ack and branch inputs must be ignored.
    for (int i = 0; i < 5; i++) begin
      br_taken   = 1'b1;
      br_offset  = 8'h7F;
      imem_ack   = (i == 2);
      imem_rdata = 16'hBEEF;
      step();
      check_output("stall_instr", instr, 16'h4000);
      check_output("stall_pc", instr_pc, 16'h0006);
      check_output("stall_req", {15'd0, imem_req}, 16'd0);
      check_output("stall_valid", {15'd0, instr_valid}, 16'd1);
      check_output("stall_count", fetch_count, 16'd3);
    end
    imem_ack = 1'b0;
    apply_accept(1'b0, 8'h00, 16'h0008, 16'd4);

    // Branches: reach 0x0010, take -3, return, then fall through.
    apply_fetch(16'h0008, 16'hC003, 0);
    apply_accept(1'b1, 8'h03, 16'h0010, 16'd5);
    apply_fetch(16'h0010, 16'hC0FD, 1);
    apply_accept(1'b1, 8'hFD, 16'h000C, 16'd6);
    apply_fetch(16'h000C, 16'hC001, 0);
    apply_accept(1'b1, 8'h01, 16'h0010, 16'd7);
    apply_fetch(16'h0010, 16'hC0FD, 0);
    apply_accept(1'b0, 8'hFD, 16'h0012, 16'd8);
    apply_fetch(16'h0012, 16'hC0F6, 0);
    apply_accept(1'b1, 8'hF6, 16'h0000, 16'd9);
    apply_fetch(16'h0000, 16'hC07F, 0);
    apply_accept(1'b1, 8'h7F, 16'h0100, 16'd10);
    apply_fetch(16'h0100, 16'hC080, 0);
    apply_accept(1'b1, 8'h80, 16'h0002, 16'd11);
    apply_fetch(16'h0002, 16'hC0FD, 0);
    apply_accept(1'b1, 8'hFD, 16'hFFFE, 16'd12);

    // Sequential wrap past the top of memory.
    apply_fetch(16'hFFFE, 16'h2222, 0);
    apply_accept(1'b0, 8'h00, 16'h0000, 16'd13);

    // Reset while a fetch is waiting; the coincident ack must be dropped.
    step();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    reset    = 1'b0;
    imem_ack = 1'b0;
    check_output("mid_rst_req", {15'd0, imem_req}, 16'd0);
    check_output("mid_rst_valid", {15'd0, instr_valid}, 16'd0);
    check_output("mid_rst_count", fetch_count, 16'd0);
    check_output("mid_rst_instr", instr, 16'h0000);
    step();
    check_output("refetch_req", {15'd0, imem_req}, 16'd1);
    check_output("refetch_addr", imem_addr, 16'h0000);
    apply_fetch(16'h0000, 16'h1234, 0);
    apply_accept(1'b0, 8'h00, 16'h0002, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
